eth_tx_frame_arbiter: RTL

ETH_TX_FRAME_ARBITER -- requirements
Module: eth_tx_frame_arbiter

---
 rtl/eth_tx_arb_pkg.sv | 17 +
 rtl/arb_rr_select.sv | 34 +++
 rtl/eth_tx_frame_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/eth_tx_arb_pkg.sv
// Shared types and default sizing for the Ethernet TX frame arbiter.
package eth_tx_arb_pkg;

   // Arbiter states: waiting for a request, forwarding a frame, discarding
   // the tail of a truncated frame.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_XFER  = 2'd1,
      ST_DRAIN = 2'd2
   } arb_state_t;

   // 1518-byte frame plus one VLAN tag.
   localparam int DEFAULT_MAX_FRAME_LENGTH = 1522;
   // Wide enough to hold DEFAULT_MAX_FRAME_LENGTH.
   localparam int DEFAULT_LENGTH_WIDTH     = 11;

endpackage

// File: rtl/arb_rr_select.sv
// Combinational round-robin picker: returns the first requesting index
// found when searching upward from last_grant+1, wrapping at PORTS.
module arb_rr_select #(
   parameter int PORTS = 2,
   parameter int IW    = (PORTS > 1) ? $clog2(PORTS) : 1
) (
   input  logic [PORTS-1:0] req,
   input  logic [IW-1:0]    last_grant,
   output logic [IW-1:0]    grant,
   output logic             grant_valid
);

   logic [IW:0] cand_idx;

   // Visit last_grant+1 .. last_grant+PORTS (mod PORTS); first hit wins, so
   // the previously granted port is considered last.
   always_comb begin
      grant       = '0;
      grant_valid = 1'b0;
      cand_idx    = '0;
      for (int k = 1; k <= PORTS; k++) begin
         // last_grant <= PORTS-1 and k <= PORTS, so one subtraction wraps.
         cand_idx = {1'b0, last_grant} + (IW+1)'(k);
         if (cand_idx >= (IW+1)'(PORTS)) begin
            cand_idx = cand_idx - (IW+1)'(PORTS);
         end
         if (!grant_valid && req[cand_idx[IW-1:0]]) begin
            grant_valid = 1'b1;
            grant       = cand_idx[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/eth_tx_frame_arbiter.sv
// Round-robin arbiter merging PORTS AXI-Stream byte sources into one MAC TX
// stream, one whole frame at a time, with oversize truncation and drain.
module eth_tx_frame_arbiter
   import eth_tx_arb_pkg::*;
#(
   parameter int PORTS            = 2,
   parameter int MAX_FRAME_LENGTH = DEFAULT_MAX_FRAME_LENGTH,
   parameter int LENGTH_WIDTH     = DEFAULT_LENGTH_WIDTH
) (
   input  logic                       tx_clk,
   input  logic                       tx_rst,
   input  logic [PORTS*8-1:0]         s_axis_tdata,
   input  logic [PORTS-1:0]           s_axis_tvalid,
   input  logic [PORTS-1:0]           s_axis_tlast,
   input  logic [PORTS-1:0]           s_axis_tuser,
   output logic [PORTS-1:0]           s_axis_tready,
   input  logic [PORTS-1:0]           port_enable,
   output logic [7:0]                 m_axis_tdata,
   output logic                       m_axis_tvalid,
   output logic                       m_axis_tlast,
   output logic                       m_axis_tuser,
   input  logic                       m_axis_tready,
   output logic [$clog2(PORTS)-1:0]   grant_port,
   output logic                       grant_active,
   output logic                       frame_done,
   output logic [LENGTH_WIDTH-1:0]    frame_length,
   output logic                       oversize
);

   localparam int GW = $clog2(PORTS);

   arb_state_t              state_reg, state_next;
   logic [GW-1:0]           grant_reg, grant_next;
   logic [GW-1:0]           last_grant_reg, last_grant_next;
   logic [LENGTH_WIDTH-1:0] count_reg, count_next;
   logic                    frame_done_reg, frame_done_next;
   logic                    oversize_reg, oversize_next;
   logic [LENGTH_WIDTH-1:0] frame_length_reg, frame_length_next;

   logic [GW-1:0]           pick_grant;
   logic                    pick_valid;
   logic [7:0]              port_data [PORTS];
   logic [7:0]              sel_data;
   logic                    sel_valid, sel_last, sel_user;
   logic                    at_limit;

   // Only enabled ports with a pending byte take part in arbitration.
   arb_rr_select #(
      .PORTS (PORTS),
      .IW    (GW)
   ) u_rr_select (
      .req         (s_axis_tvalid & port_enable),
      .last_grant  (last_grant_reg),
      .grant       (pick_grant),
      .grant_valid (pick_valid)
   );

   // Per-port byte lanes, and ready back to the granted source only: it
   // follows the MAC while forwarding and is forced high while draining.
   generate
      for (genvar gi = 0; gi < PORTS; gi++) begin : g_port
         assign port_data[gi]     = s_axis_tdata[8*gi +: 8];
         assign s_axis_tready[gi] = (grant_reg == GW'(gi)) &&
                                    (((state_reg == ST_XFER) && m_axis_tready) ||
                                     (state_reg == ST_DRAIN));
      end
   endgenerate

   assign sel_data  = port_data[grant_reg];
   assign sel_valid = s_axis_tvalid[grant_reg];
   assign sel_last  = s_axis_tlast[grant_reg];
   assign sel_user  = s_axis_tuser[grant_reg];

   // The beat at this count is the last one allowed out of a frame.
   assign at_limit = (count_reg == LENGTH_WIDTH'(MAX_FRAME_LENGTH - 1));

   assign grant_port   = grant_reg;
   assign grant_active = (state_reg != ST_IDLE);
   assign frame_done   = frame_done_reg;
   assign frame_length = frame_length_reg;
   assign oversize     = oversize_reg;

   // State register and frame bookkeeping; reset abandons any frame in flight.
   always_ff @(posedge tx_clk or posedge tx_rst) begin
      if (tx_rst) begin
         state_reg        <= ST_IDLE;
         grant_reg        <= '0;
         last_grant_reg   <= GW'(PORTS - 1);
         count_reg        <= '0;
         frame_done_reg   <= 1'b0;
         oversize_reg     <= 1'b0;
         frame_length_reg <= '0;
      end else begin
         state_reg        <= state_next;
         grant_reg        <= grant_next;
         last_grant_reg   <= last_grant_next;
         count_reg        <= count_next;
         frame_done_reg   <= frame_done_next;
         oversize_reg     <= oversize_next;
         frame_length_reg <= frame_length_next;
      end
   end

   // Next-state logic and the zero-latency output mux for the granted port.
   always_comb begin
      state_next        = state_reg;
      grant_next        = grant_reg;
      last_grant_next   = last_grant_reg;
      count_next        = count_reg;
      frame_done_next   = 1'b0;
      oversize_next     = 1'b0;
      frame_length_next = frame_length_reg;
      m_axis_tdata      = sel_data;
      m_axis_tvalid     = 1'b0;
      m_axis_tlast      = 1'b0;
      m_axis_tuser      = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            if (pick_valid) begin
               grant_next = pick_grant;
               count_next = '0;
               state_next = ST_XFER;
            end
         end

         ST_XFER: begin
            m_axis_tvalid = sel_valid;
            // At the length limit the frame is cut here and marked bad,
            // unless the source happens to end on this very beat.
            m_axis_tlast  = sel_last | at_limit;
            m_axis_tuser  = sel_user | (at_limit & ~sel_last);
            if (sel_valid && m_axis_tready) begin
               count_next = count_reg + LENGTH_WIDTH'(1);
               if (sel_last) begin
                  state_next        = ST_IDLE;
                  last_grant_next   = grant_reg;
                  frame_done_next   = 1'b1;
                  frame_length_next = count_reg + LENGTH_WIDTH'(1);
               end else if (at_limit) begin
                  state_next        = ST_DRAIN;
                  frame_done_next   = 1'b1;
                  oversize_next     = 1'b1;
                  frame_length_next = LENGTH_WIDTH'(MAX_FRAME_LENGTH);
               end
            end
         end

         ST_DRAIN: begin
            // Source bytes are swallowed until its own end of frame.
            if (sel_valid && sel_last) begin
               state_next      = ST_IDLE;
               last_grant_next = grant_reg;
            end
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

endmodule
